// File: rtl/modular_inverter_pkg.sv
// rtl/modular_inverter_pkg.sv - shared modulus table, exponent helper and FSM state type
package modular_inverter_pkg;

   localparam int WORD_W           = 30;
   localparam int MULT_LATENCY_DEF = 6;

   // Last of the 60 square/multiply operations (30 exponent bits, two ops per bit).
   localparam logic [5:0] LAST_OP = 6'd59;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // NTT-friendly primes below 2^30, one per RNS channel.
   function automatic logic [29:0] modulus_q(input int idx);
      case (idx)
         0:       return 30'd998244353;
         1:       return 30'd754974721;
         2:       return 30'd469762049;
         default: return 30'd167772161;
      endcase
   endfunction

   // Fermat exponent: a^(q-2) == a^-1 mod q.
   function automatic logic [29:0] exponent_e(input int idx);
      return modulus_q(idx) - 30'd2;
   endfunction

endpackage

// File: rtl/modular_multiplier.sv
// rtl/modular_multiplier.sv - pipelined c = a*b mod q for one RNS modulus
// Purpose: fixed-latency modular product. The caller registers a/b; this block adds
//          MULT_LATENCY-1 stages so c is valid MULT_LATENCY cycles after the operand
//          registers load. No reset and no stall: data simply flows through.
// Ports:
//   clk  in   1   rising-edge clock
//   a    in   30  registered operand, a < q
//   b    in   30  registered operand, b < q
//   c    out  30  (a*b) mod q, delayed
module modular_multiplier
   import modular_inverter_pkg::*;
#(
   parameter int mod_index    = 0,
   parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
   input  logic        clk,
   input  logic [29:0] a,
   input  logic [29:0] b,
   output logic [29:0] c
);

   localparam logic [59:0] Q60    = {30'd0, modulus_q(mod_index)};
   localparam int          STAGES = MULT_LATENCY - 1;

   logic [29:0] pipe [STAGES];

   always_ff @(posedge clk) begin
      pipe[0] <= 30'(({30'd0, a} * {30'd0, b}) % Q60);
      for (int i = 1; i < STAGES; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign c = pipe[STAGES-1];

endmodule

// File: rtl/modular_inverter.sv
// rtl/modular_inverter.sv - constant-time Fermat inverter c = a^(q-2) mod q
// Purpose: fixed-latency square-and-multiply over all 30 exponent bits (MSB first),
//          using one modular_multiplier with exactly one product in flight.
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   a is valid
//   in_ready   out  1   idle and able to accept a
//   a          in   30  operand, a < q
//   out_valid  out  1   c is valid, held until accepted
//   out_ready  in   1   consumer accepts c
//   c          out  30  a^(q-2) mod q
module modular_inverter
   import modular_inverter_pkg::*;
#(
   parameter int mod_index    = 0,
   parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [29:0] a,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [29:0] c
);

   localparam int          WCNT_W = $clog2(MULT_LATENCY + 1);
   localparam logic [29:0] E      = exponent_e(mod_index);

   state_t              state, state_n;
   logic [5:0]          op;
   logic [WCNT_W-1:0]   wcnt;
   logic [29:0]         r, a_reg, op_a, op_b;
   logic [29:0]         p;
   logic [4:0]          bit_idx;
   logic                e_bit, wait_last;
   logic [29:0]         r_next;

   modular_multiplier #(
      .mod_index    (mod_index),
      .MULT_LATENCY (MULT_LATENCY)
   ) u_mult (
      .clk (clk),
      .a   (op_a),
      .b   (op_b),
      .c   (p)
   );

   // Odd op 2k+1 conditionally multiplies for exponent bit 29-k.
   assign bit_idx   = 5'd29 - op[5:1];
   assign e_bit     = E[bit_idx];
   assign wait_last = (wcnt == WCNT_W'(MULT_LATENCY - 1));
   assign r_next    = (!op[0] || e_bit) ? p : r;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = (state == ST_IDLE);
      case (state)
         ST_IDLE:  if (in_valid) state_n = ST_ISSUE;
         ST_ISSUE: state_n = ST_WAIT;
         ST_WAIT:  if (wait_last) state_n = (op == LAST_OP) ? ST_DONE : ST_ISSUE;
         ST_DONE:  if (out_valid && out_ready) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Capture only at the terminal count of a freshly issued op, so products left in
   // the multiplier pipeline by a reset are never consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         op        <= '0;
         wcnt      <= '0;
         r         <= '0;
         a_reg     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         c         <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  r     <= 30'd1;
                  op    <= '0;
               end
            end
            ST_ISSUE: begin
               op_a <= r;
               op_b <= op[0] ? a_reg : r;
               wcnt <= '0;
            end
            ST_WAIT: begin
               wcnt <= wcnt + 1'b1;
               if (wait_last) begin
                  r <= r_next;
                  if (op == LAST_OP) c  <= r_next;
                  else               op <= op + 6'd1;
               end
            end
            ST_DONE: begin
               // out_valid is an output register, rising one cycle after DONE entry.
               if (out_valid && out_ready) out_valid <= 1'b0;
               else                        out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
